// File: rtl/vout_cmd_parser_pkg.sv
// Shared encodings for the RX command parser: system states and the
// opcode values carried in rx_data[7:4].
package vout_cmd_parser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_STREAM = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_ARM    = 4'h1;
    localparam logic [3:0] OP_DATA   = 4'h2;
    localparam logic [3:0] OP_START  = 4'h3;
    localparam logic [3:0] OP_STOP   = 4'h4;
    localparam logic [3:0] OP_STATUS = 4'h5;
    localparam logic [3:0] OP_ABORT  = 4'hF;

endpackage

// File: rtl/status_tx.sv
// Two-byte status reply shifter: load captures both bytes, cancel drops the
// reply at any point, and bytes advance on the tx_valid/tx_ready handshake.
module status_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       cancel,
    input  logic [7:0] byte0,
    input  logic [7:0] byte1,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       tx_last
);

    logic [7:0] hold;

    // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || cancel) begin
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            tx_data  <= 8'h00;
            hold     <= 8'h00;
        end else if (load && !tx_valid) begin
            tx_valid <= 1'b1;
            tx_last  <= 1'b0;
            tx_data  <= byte0;
            hold     <= byte1;
        end else if (tx_valid && tx_ready) begin
            if (tx_last) begin
                tx_valid <= 1'b0;
                tx_last  <= 1'b0;
                tx_data  <= 8'h00;
            end else begin
                tx_data <= hold;
                tx_last <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/vout_cmd_parser.sv
// RX command parser and system FSM: registers accepted bytes, decodes them one
// cycle later, packs DATA nibbles into FIFO words and answers STATUS requests.
module vout_cmd_parser
    import vout_cmd_parser_pkg::*;
#(
    parameter int DATA_W     = 4,
    parameter int FIFO_AW    = 11,
    parameter int HIGH_WATER = 1920,
    parameter int OVF_FATAL  = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    input  logic               rx_user,
    input  logic               rx_last,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               tx_last,
    output logic [DATA_W-1:0]  vout_fifow_data,
    output logic               vout_fifow_request,
    input  logic [FIFO_AW-1:0] vout_fifow_used_words,
    output logic [1:0]         state,
    output logic [7:0]         ovf_cnt
);

    localparam int          PACK   = DATA_W / 4;
    localparam int          CNT_W  = $clog2(PACK + 1);
    localparam logic [31:0] HW_LVL = HIGH_WATER;

    logic              s1_valid;
    logic              s1_last;
    logic [3:0]        s1_op;
    logic [3:0]        s1_pay;

    state_t            state_q, state_nxt;
    logic [DATA_W-1:0] pack_q, pack_nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;
    logic [7:0]        ovf_nxt;
    logic [DATA_W+3:0] shifted;
    logic [31:0]       used_ext;
    logic              data_hit, word_done, room;
    logic              wr_fire, tx_load, tx_cancel;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_op    <= 4'h0;
            s1_pay   <= 4'h0;
        end else begin
            s1_valid <= rx_valid && !rx_user;
            s1_last  <= rx_last;
            s1_op    <= rx_data[7:4];
            s1_pay   <= rx_data[3:0];
        end
    end

    assign used_ext  = 32'(vout_fifow_used_words);
    assign room      = used_ext < HW_LVL;
    assign shifted   = {pack_q, s1_pay};
    assign data_hit  = s1_valid && (s1_op == OP_DATA) && (state_q == ST_STREAM);
    assign word_done = data_hit && (cnt_q == CNT_W'(PACK - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state_q;
        if (s1_valid) begin
            case (s1_op)
                OP_ABORT: state_nxt = ST_IDLE;
                OP_ARM:   if (state_q == ST_IDLE)   state_nxt = ST_ARMED;
                OP_START: if (state_q == ST_ARMED)  state_nxt = ST_STREAM;
                OP_STOP:  if (state_q == ST_STREAM) state_nxt = ST_ARMED;
                OP_DATA:  if (word_done && !room && (OVF_FATAL != 0)) state_nxt = ST_FAULT;
                default:  state_nxt = state_q;
            endcase
        end
    end

    always_comb begin
        pack_nxt  = pack_q;
        cnt_nxt   = cnt_q;
        ovf_nxt   = ovf_cnt;
        wr_fire   = 1'b0;
        tx_load   = 1'b0;
        tx_cancel = 1'b0;
        if (s1_valid) begin
            case (s1_op)
                OP_ABORT: begin
                    pack_nxt  = '0;
                    cnt_nxt   = '0;
                    ovf_nxt   = 8'h00;
                    tx_cancel = 1'b1;
                end
                OP_START: if (state_q == ST_ARMED) begin
                    pack_nxt = '0;
                    cnt_nxt  = '0;
                end
                OP_STOP: if (state_q == ST_STREAM) begin
                    pack_nxt = '0;
                    cnt_nxt  = '0;
                end
                OP_STATUS: tx_load = 1'b1;
                OP_DATA: if (data_hit) begin
                    if (word_done) begin
                        pack_nxt = '0;
                        cnt_nxt  = '0;
                        if (room)                 wr_fire = 1'b1;
                        else if (ovf_cnt != 8'hFF) ovf_nxt = ovf_cnt + 8'd1;
                    end else begin
                        pack_nxt = shifted[DATA_W-1:0];
                        cnt_nxt  = cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
            // The frame's last byte is acted on first, then any partial pack is dropped.
            if (s1_last) begin
                pack_nxt = '0;
                cnt_nxt  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pack_q             <= '0;
            cnt_q              <= '0;
            ovf_cnt            <= 8'h00;
            vout_fifow_request <= 1'b0;
            vout_fifow_data    <= '0;
        end else begin
            pack_q             <= pack_nxt;
            cnt_q              <= cnt_nxt;
            ovf_cnt            <= ovf_nxt;
            vout_fifow_request <= wr_fire;
            if (wr_fire) vout_fifow_data <= shifted[DATA_W-1:0];
        end
    end

    assign state = state_q;

    status_tx u_status_tx (
        .clk      (clk),
        .rst      (rst),
        .load     (tx_load),
        .cancel   (tx_cancel),
        .byte0    ({OP_STATUS, 2'b00, state_q}),
        .byte1    (ovf_cnt),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_last  (tx_last)
    );

endmodule

// File: tb/tb_vout_cmd_parser.sv
// Bench for vout_cmd_parser: three configurations (PACK=1, PACK=4, PACK=1 with
// fatal overflow) share one stimulus stream and are compared against a model.
module tb_vout_cmd_parser;

    localparam int PACK_N  [3] = '{1, 4, 1};
    localparam int FATAL_N [3] = '{0, 0, 1};

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_user, rx_last, tx_ready;
    logic [10:0] used;

    logic [1:0]  st  [3];
    logic [7:0]  ovf [3];
    logic [7:0]  txd [3];
    logic        txv [3];
    logic        txl [3];
    logic        req [3];
    logic [3:0]  dat_a, dat_c;
    logic [15:0] dat_b;
    logic [15:0] dat [3];

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #4 clk = ~clk;

    vout_cmd_parser #(.DATA_W(4), .FIFO_AW(11), .HIGH_WATER(1920), .OVF_FATAL(0)) dut_a (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_user(rx_user),
        .rx_last(rx_last), .tx_data(txd[0]), .tx_valid(txv[0]), .tx_ready(tx_ready),
        .tx_last(txl[0]), .vout_fifow_data(dat_a), .vout_fifow_request(req[0]),
        .vout_fifow_used_words(used), .state(st[0]), .ovf_cnt(ovf[0]));

    vout_cmd_parser #(.DATA_W(16), .FIFO_AW(11), .HIGH_WATER(1920), .OVF_FATAL(0)) dut_b (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_user(rx_user),
        .rx_last(rx_last), .tx_data(txd[1]), .tx_valid(txv[1]), .tx_ready(tx_ready),
        .tx_last(txl[1]), .vout_fifow_data(dat_b), .vout_fifow_request(req[1]),
        .vout_fifow_used_words(used), .state(st[1]), .ovf_cnt(ovf[1]));

    vout_cmd_parser #(.DATA_W(4), .FIFO_AW(11), .HIGH_WATER(1920), .OVF_FATAL(1)) dut_c (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_user(rx_user),
        .rx_last(rx_last), .tx_data(txd[2]), .tx_valid(txv[2]), .tx_ready(tx_ready),
        .tx_last(txl[2]), .vout_fifow_data(dat_c), .vout_fifow_request(req[2]),
        .vout_fifow_used_words(used), .state(st[2]), .ovf_cnt(ovf[2]));

    assign dat[0] = {12'h000, dat_a};
    assign dat[1] = dat_b;
    assign dat[2] = {12'h000, dat_c};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: one decoded byte per cycle, a nibble accumulator per
    // configuration, and a count of reply bytes still owed to the MAC.
    int m_state [3], m_ovf [3], m_word [3], m_cnt [3];
    int rq_n [3], rq_b0 [3], rq_b1 [3];
    bit m_req [3];
    int m_data [3];
    bit m_s1_v, m_s1_last;
    int m_s1_op, m_s1_pay;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            bit pend;
            if (rst) begin
                m_state[i] = 0; m_ovf[i] = 0; m_word[i] = 0; m_cnt[i] = 0;
                rq_n[i] = 0; m_req[i] = 1'b0;
            end else begin
                m_req[i] = 1'b0;
                pend = (rq_n[i] != 0);
                if (pend && tx_ready) rq_n[i]--;
                if (m_s1_v) begin
                    case (m_s1_op)
                        'hF: begin
                            m_state[i] = 0; m_ovf[i] = 0; m_word[i] = 0; m_cnt[i] = 0; rq_n[i] = 0;
                        end
                        'h1: if (m_state[i] == 0) m_state[i] = 1;
                        'h3: if (m_state[i] == 1) begin m_state[i] = 2; m_word[i] = 0; m_cnt[i] = 0; end
                        'h4: if (m_state[i] == 2) begin m_state[i] = 1; m_word[i] = 0; m_cnt[i] = 0; end
                        'h5: if (!pend) begin
                            rq_n[i] = 2; rq_b0[i] = 'h50 + m_state[i]; rq_b1[i] = m_ovf[i];
                        end
                        'h2: if (m_state[i] == 2) begin
                            m_word[i] = m_word[i] * 16 + m_s1_pay;
                            m_cnt[i]++;
                            if (m_cnt[i] == PACK_N[i]) begin
                                if (used < 1920) begin
                                    m_req[i] = 1'b1; m_data[i] = m_word[i];
                                end else begin
                                    if (m_ovf[i] < 255) m_ovf[i]++;
                                    if (FATAL_N[i] != 0) m_state[i] = 3;
                                end
                                m_word[i] = 0; m_cnt[i] = 0;
                            end
                        end
                        default: ;
                    endcase
                    if (m_s1_last) begin m_word[i] = 0; m_cnt[i] = 0; end
                end
            end
        end
        if (rst) m_s1_v = 1'b0;
        else begin
            m_s1_v    = rx_valid && !rx_user;
            m_s1_last = rx_last;
            m_s1_op   = int'(rx_data[7:4]);
            m_s1_pay  = int'(rx_data[3:0]);
        end
    end

    int wlog_a [$];
    int wlog_b [$];

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("state%0d", i), 32'(st[i]), m_state[i]);
                check($sformatf("ovf%0d", i), 32'(ovf[i]), m_ovf[i]);
                check($sformatf("req%0d", i), 32'(req[i]), 32'(m_req[i]));
                if (m_req[i]) check($sformatf("data%0d", i), 32'(dat[i]), m_data[i]);
                check($sformatf("txv%0d", i), 32'(txv[i]), 32'(rq_n[i] != 0));
                check($sformatf("txl%0d", i), 32'(txl[i]), 32'(rq_n[i] == 1));
                if (rq_n[i] != 0)
                    check($sformatf("txd%0d", i), 32'(txd[i]), (rq_n[i] == 2) ? rq_b0[i] : rq_b1[i]);
            end
            if (req[0] === 1'b1) wlog_a.push_back(int'(dat[0]));
            if (req[1] === 1'b1) wlog_b.push_back(int'(dat[1]));
        end
    end

    task automatic send(input logic [7:0] b, input logic last = 1'b0, input logic user = 1'b0);
        rx_data = b; rx_last = last; rx_user = user; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0; rx_last = 1'b0; rx_user = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; rx_user = 1'b0; rx_last = 1'b0;
        tx_ready = 1'b1; used = 11'd0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) check($sformatf("rst_data%0d", i), 32'(dat[i]), 0);
        rst = 1'b0;
        idle(1);

        // Arm, start, stream two PACK=1 words.
        wlog_a.delete(); wlog_b.delete();
        send(8'h10); send(8'h30); send(8'h2A); send(8'h25, 1'b1);
        idle(3);
        check("plan1_state", 32'(st[0]), 2);
        check("plan1_nwr", wlog_a.size(), 2);
        if (wlog_a.size() == 2) begin
            check("plan1_w0", wlog_a[0], 'hA);
            check("plan1_w1", wlog_a[1], 'h5);
        end

        // 16-bit packing, a partial pack cut by frame end, then a fresh frame.
        wlog_b.delete();
        send(8'h21); send(8'h22); send(8'h23); send(8'h24);
        send(8'h25, 1'b1);
        send(8'h26); send(8'h27); send(8'h28); send(8'h29);
        idle(3);
        check("plan2_nwr", wlog_b.size(), 2);
        if (wlog_b.size() == 2) begin
            check("plan2_w0", wlog_b[0], 'h1234);
            check("plan2_w1", wlog_b[1], 'h6789);
        end

        // Backpressure at the high-water mark.
        wlog_a.delete();
        used = 11'd1920;
        send(8'h21); send(8'h22); send(8'h23);
        idle(3);
        check("bp_nwr", wlog_a.size(), 0);
        check("bp_ovf", 32'(ovf[0]), 3);
        check("bp_fatal_state", 32'(st[2]), 3);
        send(8'h24); send(8'h25); send(8'h26); send(8'h27);
        idle(2);
        used = 11'd0;
        check("bp_ovf7", 32'(ovf[0]), 7);

        // Status reply against a stalled MAC, with a duplicate request.
        tx_ready = 1'b0;
        send(8'h50); idle(1); send(8'h50); idle(2);
        check("tx_b0_held", 32'(txd[0]), 'h52);
        check("tx_b0_last", 32'(txl[0]), 0);
        tx_ready = 1'b1;
        @(negedge clk);
        check("tx_b1", 32'(txd[0]), 'h07);
        check("tx_b1_last", 32'(txl[0]), 1);
        @(negedge clk);
        check("tx_done", 32'(txv[0]), 0);
        idle(3);
        check("tx_no_extra", 32'(txv[0]), 0);

        // Abort from FAULT, then illegal and errored input.
        send(8'hF0); idle(2);
        check("abort_state", 32'(st[2]), 0);
        check("abort_ovf", 32'(ovf[0]), 0);
        send(8'h30); idle(2);
        check("start_in_idle", 32'(st[0]), 0);
        send(8'h10, 1'b0, 1'b1); idle(2);
        check("rx_user_drop", 32'(st[0]), 0);
        wlog_a.delete();
        send(8'h10); send(8'h2F); idle(3);
        check("data_in_armed_state", 32'(st[0]), 1);
        check("data_in_armed_nwr", wlog_a.size(), 0);

        // Reset the cycle after a DATA byte is accepted.
        send(8'h30); idle(1);
        wlog_a.delete();
        send(8'h21);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(3);
        check("rst_mid_nwr", wlog_a.size(), 0);
        check("rst_mid_state", 32'(st[0]), 0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] op;
            rst = ($urandom_range(0, 399) == 0);
            op = ($urandom_range(0, 15) < 7) ? 4'h2 : 4'($urandom_range(0, 15));
            if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h0;
            rx_data  = {op, 4'($urandom_range(0, 15))};
            rx_valid = ($urandom_range(0, 3) != 0);
            rx_user  = ($urandom_range(0, 15) == 0);
            rx_last  = ($urandom_range(0, 7) == 0);
            tx_ready = ($urandom_range(0, 2) != 0);
            used     = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(1915, 1925)) : 11'd0;
            @(negedge clk);
        end
        rst = 1'b0; rx_valid = 1'b0;
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vout_cmd_parser.md
# vout_cmd_parser

Parametrised successor to the first-generation state manager. It parses the Ethernet RX byte stream into opcode/payload pairs and runs the system state machine (IDLE/ARMED/STREAM/FAULT). In STREAM it packs payload nibbles into `DATA_W`-bit words for the video_out write FIFO, with high-water backpressure and overflow accounting. It answers status requests on the TX byte stream and sits between the Ethernet MAC wrapper and video_out, all on the 125 MHz Ethernet clock.

## Interface
- `DATA_W`, 4: FIFO word width; must be a multiple of 4. `PACK = DATA_W/4` nibbles per word.
- `FIFO_AW`, 11: width of `vout_fifow_used_words`.
- `HIGH_WATER`, 1920: used-words level at and above which writes are refused.
- `OVF_FATAL`, 0: 1 means an overflow in STREAM moves the block to FAULT.
- `clk` in 1: single clock, 125 MHz, shared with the Ethernet MAC.
- `rst` in 1: reset, synchronous, active-high.
- `rx_data` in 8: `[7:4]` opcode, `[3:0]` payload.
- `rx_valid` in 1: byte present. Every valid byte is consumed; there is no RX backpressure.
- `rx_user` in 1: MAC error flag. A byte with `rx_user=1` is dropped.
- `rx_last` in 1: last byte of frame. Any partial nibble pack is discarded at frame end.
- `tx_data` out 8: status reply byte.
- `tx_valid` out 1: reply byte valid.
- `tx_ready` in 1: MAC accepts the byte when `tx_valid && tx_ready`.
- `tx_last` out 1: marks the final reply byte.
- `vout_fifow_data` out DATA_W: packed word.
- `vout_fifow_request` out 1: single-cycle FIFO write strobe.
- `vout_fifow_used_words` in FIFO_AW: FIFO fill level.
- `state` out 2: current state. IDLE=0, ARMED=1, STREAM=2, FAULT=3.
- `ovf_cnt` out 8: saturating count of dropped words.

## Operation
- **Input stage:** a byte is accepted when `rx_valid && !rx_user`. Opcode, payload and `rx_last` are registered (stage 1). Decode and actions happen in stage 2.
- **0x0 NOP:** no effect.
- **0x1 ARM:** IDLE→ARMED.
- **0x2 DATA:** applies in STREAM only; ignored in every other state.
  - The payload is shifted into the pack register, first nibble in the MS position.
  - When the PACK-th nibble lands, the word is written.
- **0x3 START:** ARMED→STREAM. Clears the pack count.
- **0x4 STOP:** STREAM→ARMED. Discards the partial pack.
- **0x5 STATUS:** legal in any state. Loads a 2-byte reply:
  - byte0 = `{4'h5, 2'b00, state}`
  - byte1 = `ovf_cnt`, with `tx_last` set.
  - A STATUS arriving while a reply is still pending is ignored.
- **0xF ABORT:** any state→IDLE. Clears the pack register, `ovf_cnt` and any pending reply.
- **Other opcodes (including 0x6–0xE):** ignored. Opcodes outside their legal state are also ignored.
- **Write rule:** a completed word is written only if `vout_fifow_used_words < HIGH_WATER` at stage 2. Otherwise:
  - the word is dropped;
  - `ovf_cnt` increments, saturating at 255;
  - if `OVF_FATAL=1`, the state moves STREAM→FAULT.
- **FAULT:** only ABORT leaves it; STATUS is still answered.
- **Frame end:** a stage-1 byte with `rx_last` set is acted on first. The partial pack is then cleared, so packs never span frames.

## Timing
- **Latency:** byte accepted at cycle N → state change and `vout_fifow_request` (registered, one cycle wide) at N+2. `tx_valid` also rises at N+2.
- **Write cadence:** a new word every PACK accepted DATA bytes. Back-to-back writes are possible when PACK=1.
- **TX handshake:**
  - `tx_data`, `tx_valid` and `tx_last` hold until `tx_ready`.
  - byte1 is presented the cycle after byte0 is accepted.
  - `tx_valid` falls the cycle after byte1 is accepted.
- **Simultaneous events:** ABORT at stage 2 beats a pending TX byte; the reply is cancelled even mid-handshake. An overflow on the same word that completes the pack counts once.
- **Reset values:**
  - state IDLE; `ovf_cnt` 0; pack register and count 0.
  - `vout_fifow_request` 0; `vout_fifow_data` 0.
  - `tx_valid` 0; `tx_last` 0; `tx_data` 0; pipeline valids 0.
- **Reset mid-operation:** in-flight stage-1/2 bytes and the pending reply are lost. Outputs take their reset values the cycle after `rst` is sampled high.

## Structure
- A shared package holds the state encodings and the opcode constants `OP_NOP`, `OP_ARM`, `OP_DATA`, `OP_START`, `OP_STOP`, `OP_STATUS`, `OP_ABORT`.
- One sub-module, `status_tx`: a 2-byte reply shifter with load, cancel and the ready/valid handshake.
- The packer and FSM stay in the top module.

## Test plan
- **Arm/start/stream, DATA_W=4:** send bytes 0x10, 0x30, 0x2A, 0x25 → state 0→1→2; two writes, data 0xA then 0x5, at N+2 of each byte.
- **Packing, DATA_W=16:** in STREAM send 0x21, 0x22, 0x23, 0x24 → one write of 0x1234. Then send 0x25 with `rx_last` → no write, and the next frame starts a fresh pack.
- **Backpressure:** hold `used_words`=1920 and send 3 DATA bytes (PACK=1) → no requests, `ovf_cnt`=3. With OVF_FATAL=1, state=3; then send 0xF0 → state 0, `ovf_cnt` 0.
- **Status with stalled TX:** in STREAM with `ovf_cnt`=7, send 0x50 while holding `tx_ready`=0 for 5 cycles → byte0=0x52 held stable. Then byte1=0x07 with `tx_last`. A second 0x50 sent during the stall produces no extra bytes.
- **Error/illegal input:** 0x30 in IDLE → stays IDLE. 0x10 with `rx_user`=1 → ignored. 0x2F in ARMED → no write.
- **Reset mid-stream:** pulse `rst` one cycle after accepting a DATA byte → no write, all outputs at reset values, state IDLE.
